tour_cmd_seq: RTL
=================

Name: tour_cmd_seq

Overview:
- Consumer side of the knight's-tour solution store: walks the solved move list by index and converts each one-hot knight move into two robot motion commands.
- The first command is a 2-square leg; the second is a 1-square leg.
- Sits between the tour solver (indexed move read port) and the command processor (valid/ready command port plus a move-complete response).
- Paces itself on that response, so only one leg is ever in flight.

Parameters:
- NUM_MOVES, 24, number of moves read from the solver (indices 0..NUM_MOVES-1).
- IDX_W, 5, width of the move index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_tour  in  1  single-cycle pulse; begins sequencing from index 0.
- move  in  8  one-hot move at the solver location addressed by mv_indx; combinational from the solver.
- mv_indx  out  IDX_W  index of the move currently being fetched or executed.
- cmd  out  16  motion command: [15:12] opcode, [11:4] heading, [3:0] squares.
- cmd_vld  out  1  cmd is valid.
- cmd_rdy  in  1  command processor accepts cmd this cycle.
- resp_done  in  1  single-cycle pulse; the commanded leg has finished.
- busy  out  1  high from start acceptance until tour completion.
- tour_done  out  1  one-cycle pulse after the final leg's resp_done.
- mv_err  out  1  sticky; set when a fetched move is not one-hot.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-tour or mid-handshake):
  - State goes to IDLE.
  - mv_indx=0, cmd=16'h0000, cmd_vld=0, busy=0, tour_done=0, mv_err=0.
  - Latched move is cleared.
- States: IDLE, LOAD, LEG1, WAIT1, LEG2, WAIT2, NEXT.
- IDLE:
  - On start_tour: mv_indx<=0, mv_err<=0, busy<=1, go to LOAD.
  - start_tour in any other state is ignored.
- LOAD (1 cycle):
  - Register move into mv_lat.
  - If mv_lat is not one-hot (zero or multiple bits set): set mv_err, skip to NEXT with no commands issued.
  - Otherwise go to LEG1.
- Decode per move bit (dx,dy):
  - b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1), b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1).
  - Leg 1 always covers the |2| axis; leg 2 covers the |1| axis.
- Headings: +y 8'h00, -y 8'h7F, -x 8'h3F, +x 8'hBF.
- Squares: leg 1 = 4'h2, leg 2 = 4'h1.
- Opcode: 4'h2 (move). See Optional Feature for the exception.
- LEG1 / LEG2:
  - cmd is driven from registers and cmd_vld=1.
  - cmd must stay stable while cmd_vld=1 and cmd_rdy=0.
  - The cycle with cmd_vld&cmd_rdy completes the transfer. The next cycle has cmd_vld=0 and the state moves to WAIT1 / WAIT2.
  - cmd_vld is never high in any other state.
- WAIT1 / WAIT2:
  - Hold until resp_done, then go to LEG2 / NEXT respectively.
  - resp_done in any state other than WAIT1/WAIT2 is ignored and not remembered.
- NEXT:
  - If mv_indx==NUM_MOVES-1: pulse tour_done for exactly one cycle, busy<=0, mv_indx<=0, go to IDLE.
  - Else mv_indx<=mv_indx+1 and go to LOAD.
- Timing:
  - Minimum latency from start_tour to first cmd_vld is 2 cycles (IDLE->LOAD->LEG1).
  - mv_indx never exceeds NUM_MOVES-1 and does not wrap mid-tour.
- Width: mv_indx increments at IDX_W bits; NUM_MOVES must be <= 2^IDX_W.

Optional Feature:
- Macro: TOUR_FANFARE_EN.
- Defined: the leg-2 command of the final move (mv_indx==NUM_MOVES-1) uses opcode 4'h3 (move with fanfare). All other legs use 4'h2.
- Undefined: every leg uses opcode 4'h2; no fanfare logic is synthesised.

Test Plan:
- Single-move tour (NUM_MOVES=1), move=8'h01, cmd_rdy tied 1, resp_done pulsed 3 cycles after each accept:
  - Expect cmd=16'h2002, then cmd=16'h2BF1.
  - tour_done pulses once; busy falls with it.
- move=8'h08:
  - Expect legs 16'h23F2 then 16'h27F1.
  - With move=8'h40: 16'h2BF2 then 16'h27F1.
- Backpressure: hold cmd_rdy=0 for 10 cycles during LEG1.
  - cmd_vld stays 1 and cmd is unchanged every cycle.
  - Exactly one transfer occurs when cmd_rdy rises.
- Full 24-move tour from a behavioural move table:
  - 48 commands in index order; mv_indx steps 0..23.
  - tour_done is a single pulse after the 48th resp_done.
  - With TOUR_FANFARE_EN defined, only the 48th command has opcode 4'h3.
- Illegal move:
  - move=8'h00 at index 3: mv_err set, no commands issued for index 3, sequencing continues at index 4.
  - move=8'h11 behaves the same way.
- Reset and stray inputs:
  - Assert rst while cmd_vld=1 at index 7: outputs return to reset values immediately; a new start_tour begins at index 0.
  - start_tour and stray resp_done while busy have no effect.

Source files
------------

// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: fetches one-hot moves by index and issues a 2-square leg then a 1-square leg.
// Optional macro TOUR_FANFARE_EN: final move's second leg uses the fanfare opcode.
`timescale 1ns/1ps
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    output logic [15:0]      cmd,
    output logic             cmd_vld,
    input  logic             cmd_rdy,
    input  logic             resp_done,
    output logic             busy,
    output logic             tour_done,
    output logic             mv_err
);

    typedef enum logic [2:0] {IDLE, LOAD, LEG1, WAIT1, LEG2, WAIT2, NEXT} state_t;

    localparam logic [3:0]       OP_MOVE  = 4'h2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    state_t     state, nxt_state;
    logic [7:0] mv_lat;
    logic       move_ok;
    logic       last_move;
    logic [3:0] leg2_op;

    assign move_ok   = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);
    assign last_move = (mv_indx == LAST_IDX);

`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] OP_FANFARE = 4'h3;
    assign leg2_op = last_move ? OP_FANFARE : OP_MOVE;
`else
    assign leg2_op = OP_MOVE;
`endif

    // Leg 1 travels the axis with the 2-square displacement.
    function automatic logic [7:0] leg1_heading(input logic [7:0] m);
        logic [7:0] h;
        h = 8'h00;
        case (m)
            8'h01, 8'h02: h = 8'h00;
            8'h04, 8'h08: h = 8'h3F;
            8'h10, 8'h20: h = 8'h7F;
            8'h40, 8'h80: h = 8'hBF;
            default:      h = 8'h00;
        endcase
        return h;
    endfunction

    function automatic logic [7:0] leg2_heading(input logic [7:0] m);
        logic [7:0] h;
        h = 8'h00;
        case (m)
            8'h01, 8'h20: h = 8'hBF;
            8'h02, 8'h10: h = 8'h3F;
            8'h04, 8'h80: h = 8'h00;
            8'h08, 8'h40: h = 8'h7F;
            default:      h = 8'h00;
        endcase
        return h;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (start_tour) nxt_state = LOAD;
            LOAD:    nxt_state = move_ok ? LEG1 : NEXT;
            LEG1:    if (cmd_rdy) nxt_state = WAIT1;
            WAIT1:   if (resp_done) nxt_state = LEG2;
            LEG2:    if (cmd_rdy) nxt_state = WAIT2;
            WAIT2:   if (resp_done) nxt_state = NEXT;
            NEXT:    nxt_state = last_move ? IDLE : LOAD;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_vld = (state == LEG1) || (state == LEG2);
    end

    // cmd is loaded one cycle before each LEG state so it is stable throughout backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv_indx   <= '0;
            cmd       <= 16'h0000;
            busy      <= 1'b0;
            tour_done <= 1'b0;
            mv_err    <= 1'b0;
            mv_lat    <= 8'h00;
        end else begin
            tour_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx <= '0;
                        mv_err  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    mv_lat <= move;
                    if (move_ok) cmd <= {OP_MOVE, leg1_heading(move), 4'h2};
                    else         mv_err <= 1'b1;
                end
                WAIT1: begin
                    if (resp_done) cmd <= {leg2_op, leg2_heading(mv_lat), 4'h1};
                end
                NEXT: begin
                    if (last_move) begin
                        tour_done <= 1'b1;
                        busy      <= 1'b0;
                        mv_indx   <= '0;
                    end else begin
                        mv_indx <= mv_indx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
